jts16_obj_drawz: RTL and testbench

Parametrised sprite line drawer with hardware horizontal zoom, selectable ROM word width and a runaway-sprite guard. It sits between the object scan engine and the line buffer. Per sprite it fetches graphics words from SDRAM, unpacks 4-bit pixels, drops pixels as the zoom accumulator requires, and writes opaque pixels into the line buffer.

---
 rtl/jts16_obj_pkg.sv | 18 +
 rtl/jts16_obj_hzoom.sv | 41 ++++
 rtl/jts16_obj_drawz.sv | 179 +++++++++++++++++
 tb/tb_jts16_obj_drawz.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jts16_obj_pkg.sv
// rtl/jts16_obj_pkg.sv - shared state encoding and constants for the zooming sprite line drawer
package jts16_obj_pkg;

  typedef enum logic [1:0] {
    OBJ_IDLE = 2'd0,
    OBJ_REQ  = 2'd1,
    OBJ_DRAW = 2'd2
  } obj_st_e;

  // Pixel value that is never written to the line buffer
  localparam logic [3:0] OBJ_TRANSP = 4'hF;

  // 4-bit pixels packed in one graphics word
  function automatic int obj_ppw(input int dw);
    return dw / 4;
  endfunction

endpackage

// File: rtl/jts16_obj_hzoom.sv
// rtl/jts16_obj_hzoom.sv - horizontal zoom accumulator deciding which pixels are dropped
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      sprite launch: captures hzoom and presets the accumulator
//   step      one pixel consumed: accumulator advances
//   hzoom     zoom step, 0 = 1:1
//   skip      current pixel is dropped (accumulator overflows on this step)
module jts16_obj_hzoom (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [4:0] hzoom,
  output logic       skip
);

  logic [4:0] hz_r;
  logic [6:0] hzcnt;
  logic [7:0] hzsum;

  // The accumulator works in quarter units: the preset and the per-pixel step
  // are both hzoom*4, so hzoom=16 drops every other pixel and hzoom=0 drops none.
  always_comb begin
    hzsum = {1'b0, hzcnt} + {1'b0, hz_r, 2'b00};
    skip  = hzsum[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_r  <= '0;
      hzcnt <= '0;
    end else if (load) begin
      hz_r  <= hzoom;
      hzcnt <= {hzoom, 2'b00};
    end else if (step) begin
      hzcnt <= hzsum[6:0];
    end
  end

endmodule

// File: rtl/jts16_obj_drawz.sv
// rtl/jts16_obj_drawz.sv - sprite line drawer: fetches words, unpacks pixels, zooms, writes line buffer
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   hstart            line start, aborts any sprite in progress
//   start, busy       sprite launch pulse and in-progress flag
//   xpos, offset,     sprite attributes sampled on start
//   bank, prio, pal,
//   hzoom, hflip
//   obj_cs, obj_addr, graphics fetch request; obj_ok qualifies obj_data
//   obj_data, obj_ok
//   bf_data, bf_we,   registered line-buffer write {prio, pal, pixel}
//   bf_addr
module jts16_obj_drawz
  import jts16_obj_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 20,
  parameter int OFFW    = 16,
  parameter int PALW    = 6,
  parameter int PRIOW   = 2,
  parameter int XW      = 9,
  parameter int MAXW    = 64,
  parameter int FLIPSRC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hstart,
  input  logic                  start,
  output logic                  busy,
  input  logic [XW-1:0]         xpos,
  input  logic [OFFW-1:0]       offset,
  input  logic [AW-OFFW-1:0]    bank,
  input  logic [PRIOW-1:0]      prio,
  input  logic [PALW-1:0]       pal,
  input  logic [4:0]            hzoom,
  input  logic                  hflip,
  output logic                  obj_cs,
  output logic [AW-1:0]         obj_addr,
  input  logic [DW-1:0]         obj_data,
  input  logic                  obj_ok,
  output logic [PRIOW+PALW+3:0] bf_data,
  output logic                  bf_we,
  output logic [XW-1:0]         bf_addr
);

  localparam int PPW = obj_ppw(DW);
  localparam int NW  = $clog2(PPW);
  localparam int WCW = $clog2(MAXW + 1);

  obj_st_e st, st_nx;

  logic [OFFW-1:0]    cur;
  logic [AW-OFFW-1:0] bank_r;
  logic [XW-1:0]      xcur;
  logic [PRIOW-1:0]   prio_r;
  logic [PALW-1:0]    pal_r;
  logic               flip_r;
  logic [DW-1:0]      sh;
  logic [NW-1:0]      ncnt;
  logic [WCW-1:0]     wcnt;
  logic               fresh;

  logic               flip_in;
  logic               accept;
  logic               drawing;
  logic               last_nib;
  logic               finish;
  logic               advance;
  logic [3:0]         pix;
  logic               zload;
  logic               zstep;
  logic               skip;

  assign obj_addr = {bank_r, cur};
  assign flip_in  = (FLIPSRC != 0) ? hflip : offset[OFFW-1];

  jts16_obj_hzoom u_hzoom (
    .clk   (clk),
    .rst   (rst),
    .load  (zload),
    .step  (zstep),
    .hzoom (hzoom),
    .skip  (skip)
  );

  always_comb begin
    st_nx    = st;
    pix      = flip_r ? sh[3:0] : sh[DW-1 -: 4];
    drawing  = (st == OBJ_DRAW);
    // obj_ok in the first cycle after an address change may belong to the old address
    accept   = (st == OBJ_REQ) && obj_cs && obj_ok && !fresh;
    last_nib = drawing && (ncnt == NW'(PPW - 1));
    finish   = last_nib && ((pix == OBJ_TRANSP) || (wcnt == WCW'(MAXW)));
    advance  = last_nib && !finish;
    zload    = start && !hstart;
    zstep    = drawing && !start && !hstart;

    if (hstart) begin
      st_nx = OBJ_IDLE;
    end else if (start) begin
      st_nx = OBJ_REQ;
    end else begin
      case (st)
        OBJ_REQ:  if (accept) st_nx = OBJ_DRAW;
        OBJ_DRAW: begin
          if (finish)       st_nx = OBJ_IDLE;
          else if (advance) st_nx = OBJ_REQ;
        end
        default:  st_nx = OBJ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= OBJ_IDLE;
      busy    <= 1'b0;
      obj_cs  <= 1'b0;
      bf_we   <= 1'b0;
      bf_addr <= '0;
      bf_data <= '0;
      cur     <= '0;
      bank_r  <= '0;
      xcur    <= '0;
      prio_r  <= '0;
      pal_r   <= '0;
      flip_r  <= 1'b0;
      sh      <= '0;
      ncnt    <= '0;
      wcnt    <= '0;
      fresh   <= 1'b0;
    end else begin
      st    <= st_nx;
      bf_we <= 1'b0;
      fresh <= 1'b0;
      if (hstart) begin
        busy   <= 1'b0;
        obj_cs <= 1'b0;
      end else if (start) begin
        cur    <= offset;
        bank_r <= bank;
        xcur   <= xpos;
        prio_r <= prio;
        pal_r  <= pal;
        flip_r <= flip_in;
        wcnt   <= '0;
        obj_cs <= 1'b1;
        busy   <= 1'b1;
        fresh  <= 1'b1;
      end else begin
        if (accept) begin
          sh     <= obj_data;
          obj_cs <= 1'b0;
          wcnt   <= wcnt + 1'b1;
          ncnt   <= '0;
        end
        if (drawing) begin
          ncnt <= ncnt + 1'b1;
          sh   <= flip_r ? (sh >> 4) : (sh << 4);
          // Dropped pixels leave the write address where it is
          if (!skip) begin
            bf_data <= {prio_r, pal_r, pix};
            bf_we   <= (pix != OBJ_TRANSP);
            bf_addr <= xcur;
            xcur    <= xcur + 1'b1;
          end
          if (finish) busy <= 1'b0;
          if (advance) begin
            cur    <= flip_r ? (cur - 1'b1) : (cur + 1'b1);
            obj_cs <= 1'b1;
            fresh  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jts16_obj_drawz.sv
// tb/tb_jts16_obj_drawz.sv - scoreboard bench for the zooming sprite line drawer
module tb_jts16_obj_drawz;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hstart = 1'b0, start_a = 1'b0, start_b = 1'b0, hflip = 1'b0;
  logic [8:0]  xpos = '0;
  logic [15:0] offset = '0;
  logic [3:0]  bank = '0;
  logic [1:0]  prio = '0;
  logic [5:0]  pal = '0;
  logic [4:0]  hzoom = '0;

  logic        busy_a, cs_a, we_a, ok_a = 1'b0;
  logic [19:0] addr_a;
  logic [15:0] data_a = '0;
  logic [11:0] bfd_a;
  logic [8:0]  bfa_a;

  logic        busy_b, cs_b, we_b, ok_b = 1'b0;
  logic [19:0] addr_b;
  logic [31:0] data_b = '0;
  logic [11:0] bfd_b;
  logic [8:0]  bfa_b;

  always #5 clk = ~clk;

  jts16_obj_drawz #(.DW(16), .MAXW(4), .FLIPSRC(1)) u_a (
    .clk(clk), .rst(rst), .hstart(hstart), .start(start_a), .busy(busy_a),
    .xpos(xpos), .offset(offset), .bank(bank), .prio(prio), .pal(pal),
    .hzoom(hzoom), .hflip(hflip), .obj_cs(cs_a), .obj_addr(addr_a),
    .obj_data(data_a), .obj_ok(ok_a), .bf_data(bfd_a), .bf_we(we_a), .bf_addr(bfa_a)
  );

  jts16_obj_drawz #(.DW(32), .MAXW(64), .FLIPSRC(0)) u_b (
    .clk(clk), .rst(rst), .hstart(hstart), .start(start_b), .busy(busy_b),
    .xpos(xpos), .offset(offset), .bank(bank), .prio(prio), .pal(pal),
    .hzoom(hzoom), .hflip(hflip), .obj_cs(cs_b), .obj_addr(addr_b),
    .obj_data(data_b), .obj_ok(ok_b), .bf_data(bfd_b), .bf_we(we_b), .bf_addr(bfa_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Graphics memory shared by both instances; unwritten words read as all-transparent
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] mem_rd(input logic [19:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 32'hFFFF_FFFF;
  endfunction

  // SDRAM responder; in stale mode obj_ok never drops and data trails the address by one cycle
  logic        stale = 1'b0;
  logic [19:0] pa_a = '0, pa_b = '0;
  int          lat_a = 0, lat_b = 0;
  logic        csd_a = 1'b0, csd_b = 1'b0;
  logic [31:0] fetch_a[$], fetch_b[$];

  always @(negedge clk) begin
    pa_a  <= addr_a;
    lat_a <= (!cs_a || addr_a != pa_a) ? 0 : lat_a + 1;
    ok_a  <= stale ? 1'b1 : (cs_a && addr_a == pa_a && lat_a >= 1);
    data_a <= stale ? 16'(mem_rd(pa_a)) : 16'(mem_rd(addr_a));
    csd_a <= cs_a;
    if (cs_a && (!csd_a || addr_a != pa_a)) fetch_a.push_back({12'd0, addr_a});
    pa_b  <= addr_b;
    lat_b <= (!cs_b || addr_b != pa_b) ? 0 : lat_b + 1;
    ok_b  <= stale ? 1'b1 : (cs_b && addr_b == pa_b && lat_b >= 1);
    data_b <= stale ? mem_rd(pa_b) : mem_rd(addr_b);
    csd_b <= cs_b;
    if (cs_b && (!csd_b || addr_b != pa_b)) fetch_b.push_back({12'd0, addr_b});
  end

  typedef struct packed {
    logic [8:0]  a;
    logic [11:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] exp_f[$];
  int          sel = 0;
  int          cyc = 0;
  int          last_we = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic sb_pop(input logic [8:0] a, input logic [11:0] d);
    wr_t e;
    if (exp_q.size() == 0) begin
      check_val("extra_write", {11'd0, a, d}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("wr_addr", {23'd0, a}, {23'd0, e.a});
      check_val("wr_data", {20'd0, d}, {20'd0, e.d});
    end
  endtask

  always @(negedge clk) begin
    if (sel == 1 && we_a) sb_pop(bfa_a, bfd_a);
    if (sel == 2 && we_b) sb_pop(bfa_b, bfd_b);
    if (we_a || we_b) last_we <= cyc;
  end

  // Reference behaviour of one sprite: fetch order and the writes it must produce
  task automatic model(input int ppw, input logic [15:0] off, input bit flip,
                       input int x0, input int hz, input int maxw);
    int          hzc, x, wc, sum;
    logic [15:0] c;
    logic [31:0] w;
    logic [3:0]  p;
    bit          done;
    wr_t         e;
    hzc = hz * 4; x = x0; c = off; wc = 0; done = 0;
    exp_q.delete();
    exp_f.delete();
    while (!done) begin
      exp_f.push_back({12'd0, bank, c});
      w = mem_rd({bank, c});
      wc++;
      for (int n = 0; n < ppw; n++) begin
        p = flip ? w[4*n +: 4] : w[4*(ppw-1-n) +: 4];
        sum = hzc + hz * 4;
        hzc = sum % 128;
        if (sum < 128) begin
          if (p != 4'hF) begin
            e.a = 9'(x);
            e.d = {prio, pal, p};
            exp_q.push_back(e);
          end
          x = (x + 1) % 512;
        end
        if (n == ppw - 1) begin
          if (p == 4'hF || wc == maxw) done = 1;
          else c = flip ? c - 16'd1 : c + 16'd1;
        end
      end
    end
  endtask

  task automatic run(input int inst, input logic [15:0] off, input int x0, input int hz,
                     input bit fl, input int maxw, input bit stl, input bit tail);
    logic [31:0] got[$];
    int          n;
    model((inst == 1) ? 4 : 8, off, (inst == 1) ? fl : off[15], x0, hz, maxw);
    stale = stl;
    fetch_a.delete();
    fetch_b.delete();
    offset = off; xpos = 9'(x0); hzoom = 5'(hz); hflip = fl; sel = inst;
    @(posedge clk); #1;
    if (inst == 1) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    check_val("cs_after_start", (inst == 1) ? cs_a : cs_b, 1);
    check_val("busy_after_start", (inst == 1) ? busy_a : busy_b, 1);
    n = 0;
    @(negedge clk);
    while (((inst == 1) ? busy_a : busy_b) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("busy_timeout", (n < 500) ? 1 : 0, 1);
    if (tail) check_val("busy_fall_delay", cyc - last_we, 1);
    repeat (3) @(negedge clk);
    check_val("pending_writes", exp_q.size(), 0);
    if (inst == 1) got = fetch_a; else got = fetch_b;
    check_val("fetch_count", got.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < got.size(); i++)
      check_val("fetch_addr", got[i], exp_f[i]);
    sel = 0;
    stale = 1'b0;
  endtask

  initial begin
    int n;
    bit bad;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_cs", cs_a, 0);
    check_val("rst_we", we_a, 0);
    check_val("rst_bf_addr", bfa_a, 0);
    check_val("rst_obj_addr", addr_a, 0);
    check_val("rst_bf_data", bfd_a, 0);

    // 1:1 sprite ending on a transparent last nibble
    bank = 4'd0; prio = 2'd1; pal = 6'h15;
    mem[32'h20] = 32'h0000_123F;
    run(1, 16'h0020, 10, 0, 1'b0, 4, 1'b0, 1'b1);

    // Flipped sprite walking backwards, with stale obj_ok around every address change
    prio = 2'd3; pal = 6'h3F;
    mem[100] = 32'h0000_0005;
    mem[99]  = 32'h0000_F000;
    run(1, 16'd100, 30, 0, 1'b1, 4, 1'b1, 1'b1);

    // Half zoom: every other pixel dropped across word boundaries
    prio = 2'd2; pal = 6'h0A;
    mem[400] = 32'h0000_1234;
    mem[401] = 32'h0000_5678;
    mem[402] = 32'h0000_FFFF;
    run(1, 16'd400, 50, 16, 1'b0, 4, 1'b0, 1'b0);

    // Runaway sprite stopped by the word limit
    for (int i = 0; i < 6; i++) mem[200 + i] = 32'h0000_1234;
    run(1, 16'd200, 100, 0, 1'b0, 4, 1'b0, 1'b0);

    // Wide words with line-buffer wrap, then flip taken from the offset MSB
    bank = 4'd1; prio = 2'd0; pal = 6'h21;
    mem[32'h1_0010] = 32'h1234_567F;
    run(2, 16'h0010, 510, 0, 1'b0, 64, 1'b0, 1'b1);
    mem[32'h1_8005] = 32'hF000_0021;
    run(2, 16'h8005, 7, 0, 1'b0, 64, 1'b0, 1'b1);
    bank = 4'd0;

    // Line start while drawing
    mem[300] = 32'h0000_1111;
    offset = 16'd300; xpos = 9'd20; hzoom = 5'd0; hflip = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while (!we_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("draw_reached", we_a, 1);
    @(posedge clk); #1 hstart = 1'b1;
    @(posedge clk); #1 hstart = 1'b0;
    check_val("hstart_we", we_a, 0);
    check_val("hstart_busy", busy_a, 0);
    check_val("hstart_cs", cs_a, 0);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (we_a || cs_a || busy_a) bad = 1;
    end
    check_val("hstart_quiet", bad, 0);

    // Line start beats a simultaneous launch
    @(posedge clk); #1 start_a = 1'b1; hstart = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; hstart = 1'b0;
    check_val("hstart_wins_busy", busy_a, 0);
    check_val("hstart_wins_cs", cs_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
